// File: rtl/cfg_sched_pkg.sv
// Shared types and constants for the column configuration scheduler.
package cfg_sched_pkg;

  localparam int CFG_WORD_W              = 32;
  localparam int CLB_TILE_BITSTREAM_SIZE = 64;
  localparam int NUM_ROWS                = 16;
  localparam int CFG_BITS_PER_COL        = CLB_TILE_BITSTREAM_SIZE * NUM_ROWS;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_COMMIT,
    ST_DONE
  } sched_state_e;

  // Index width that stays legal when the count collapses to a single entry.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cfg_word_serializer.sv
// Holds one bitstream word and presents it LSB-first, flagging its final bit.
module cfg_word_serializer #(
  parameter int WORD_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic              shift_i,
  input  logic [WORD_W-1:0] data_i,
  output logic              bit_o,
  output logic              last_bit_o
);

  localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  logic [WORD_W-1:0] sreg_q;
  logic [IDX_W-1:0]  idx_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sreg_q <= '0;
      idx_q  <= '0;
    end else if (load_i) begin
      sreg_q <= data_i;
      idx_q  <= '0;
    end else if (shift_i) begin
      sreg_q <= sreg_q >> 1;
      idx_q  <= idx_q + IDX_W'(1);
    end
  end

  assign bit_o      = sreg_q[0];
  assign last_bit_o = (idx_q == IDX_W'(WORD_W - 1));

endmodule

// File: rtl/cfg_column_scheduler.sv
// Streams bitstream words into per-column config chains, one column at a time,
// and releases fabric reset once every column has been committed.
module cfg_column_scheduler
  import cfg_sched_pkg::*;
#(
  parameter int NUM_COLS     = 2,
  parameter int BITS_PER_COL = CFG_BITS_PER_COL,
  parameter int WORD_W       = CFG_WORD_W
) (
  input  logic                                   wb_clk_i,
  input  logic                                   wb_rst_i,
  input  logic                                   start,
  input  logic                                   abort,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [WORD_W-1:0]                      in_data,
  output logic                                   shift_out,
  output logic [NUM_COLS-1:0]                    cen,
  output logic [NUM_COLS-1:0]                    set_out,
  output logic                                   busy,
  output logic                                   done,
  output logic                                   fpga_rst_o,
  output logic [idx_width(NUM_COLS)-1:0]         col_idx,
  output logic [$clog2(BITS_PER_COL+1)-1:0]      bit_cnt
);

  localparam int COL_W = idx_width(NUM_COLS);
  localparam int CNT_W = $clog2(BITS_PER_COL + 1);

  sched_state_e        state_q, state_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NUM_COLS-1:0] set_q, set_d;
  logic                done_q, done_d;
  logic                frst_q, frst_d;
  logic                shift_en;
  logic                ser_bit;
  logic                word_last;
  logic                col_last_bit;
  logic                col_last;
  logic                busy_w;

  assign busy_w       = (state_q == ST_LOAD) || (state_q == ST_SHIFT) || (state_q == ST_COMMIT);
  assign col_last_bit = (cnt_q == CNT_W'(BITS_PER_COL - 1));
  assign col_last     = (col_q == COL_W'(NUM_COLS - 1));

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
      col_q   <= '0;
      cnt_q   <= '0;
      set_q   <= '0;
      done_q  <= 1'b0;
      frst_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      cnt_q   <= cnt_d;
      set_q   <= set_d;
      done_q  <= done_d;
      frst_q  <= frst_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    cnt_d    = cnt_q;
    set_d    = set_q;
    done_d   = done_q;
    frst_d   = frst_q;
    shift_en = 1'b0;
    // Abort outranks everything, including a coincident start.
    if (abort && busy_w) begin
      state_d = ST_IDLE;
      set_d   = '0;
      done_d  = 1'b0;
      frst_d  = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start && !abort) begin
            state_d = ST_LOAD;
            set_d   = '0;
            col_d   = '0;
            cnt_d   = '0;
            done_d  = 1'b0;
            frst_d  = 1'b1;
          end
        end
        ST_LOAD: begin
          if (in_valid) state_d = ST_SHIFT;
        end
        ST_SHIFT: begin
          shift_en = 1'b1;
          cnt_d    = cnt_q + CNT_W'(1);
          // Column end wins over word end: leftover word bits are discarded.
          if (col_last_bit)   state_d = ST_COMMIT;
          else if (word_last) state_d = ST_LOAD;
        end
        ST_COMMIT: begin
          set_d[col_q] = 1'b1;
          if (col_last) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            frst_d  = 1'b0;
          end else begin
            state_d = ST_LOAD;
            col_d   = col_q + COL_W'(1);
            cnt_d   = '0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  cfg_word_serializer #(
    .WORD_W (WORD_W)
  ) u_ser (
    .clk_i      (wb_clk_i),
    .rst_i      (wb_rst_i),
    .load_i     (in_valid && in_ready),
    .shift_i    (shift_en),
    .data_i     (in_data),
    .bit_o      (ser_bit),
    .last_bit_o (word_last)
  );

  always_comb begin
    cen = '0;
    if (state_q == ST_SHIFT) cen[col_q] = 1'b1;
  end

  assign in_ready   = (state_q == ST_LOAD);
  assign shift_out  = (state_q == ST_SHIFT) && ser_bit;
  assign set_out    = set_q;
  assign busy       = busy_w;
  assign done       = done_q;
  assign fpga_rst_o = frst_q;
  assign col_idx    = col_q;
  assign bit_cnt    = cnt_q;

endmodule

// File: tb/tb_cfg_column_scheduler.sv
// Directed bench for cfg_column_scheduler with two 40-bit columns.
module tb_cfg_column_scheduler;

  localparam int NC  = 2;
  localparam int BPC = 40;
  localparam int WW  = 32;

  logic          wb_clk_i = 1'b0;
  logic          wb_rst_i = 1'b1;
  logic          start    = 1'b0;
  logic          abort    = 1'b0;
  logic          in_valid = 1'b0;
  logic [WW-1:0] in_data  = '0;
  logic          in_ready;
  logic          shift_out;
  logic [NC-1:0] cen;
  logic [NC-1:0] set_out;
  logic          busy;
  logic          done;
  logic          fpga_rst_o;
  logic [0:0]    col_idx;
  logic [5:0]    bit_cnt;

  int checks = 0;
  int errors = 0;
  int k_tot;
  int wp;
  logic [3:0][31:0] cur_words;
  bit cur_toggle;

  typedef struct {
    logic [3:0][31:0] words;
    bit               toggle;
    logic [1:0]       exp_set;
    int               exp_bits;
  } vec_t;

  vec_t vecs[3];

  cfg_column_scheduler #(
    .NUM_COLS     (NC),
    .BITS_PER_COL (BPC),
    .WORD_W       (WW)
  ) dut (
    .wb_clk_i   (wb_clk_i),
    .wb_rst_i   (wb_rst_i),
    .start      (start),
    .abort      (abort),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .shift_out  (shift_out),
    .cen        (cen),
    .set_out    (set_out),
    .busy       (busy),
    .done       (done),
    .fpga_rst_o (fpga_rst_o),
    .col_idx    (col_idx),
    .bit_cnt    (bit_cnt)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0][31:0] mk(input logic [31:0] w0, input logic [31:0] w1,
                                          input logic [31:0] w2, input logic [31:0] w3);
    return {w3, w2, w1, w0};
  endfunction

  // Called at a falling edge; leaves the DUT in LOAD at the next falling edge.
  task automatic begin_pass(input logic [3:0][31:0] w, input bit tog);
    cur_words  = w;
    cur_toggle = tog;
    k_tot      = 0;
    wp         = 0;
    start      = 1'b1;
    @(negedge wb_clk_i);
    start      = 1'b0;
  endtask

  // Feeds words and checks every shifted bit until done or stop_bits cen cycles seen.
  task automatic feed(input int stop_bits);
    int cyc = 0;
    bit ph = 1'b0;
    int c, k, idx;
    logic [31:0] wd;
    while (!done && k_tot < stop_bits && cyc < 1000) begin
      chk("cen_during_load", {31'b0, in_ready & (|cen)}, 32'd0);
      if (cen != '0) begin
        c   = k_tot / BPC;
        k   = k_tot % BPC;
        idx = c * 2 + k / WW;
        wd  = cur_words[idx];
        chk("cen_onehot", {30'b0, cen}, 32'(1 << c));
        chk("shift_bit", {31'b0, shift_out}, {31'b0, wd[k % WW]});
        chk("bit_cnt_shift", {26'b0, bit_cnt}, 32'(k));
        chk("col_idx_shift", {31'b0, col_idx}, 32'(c));
        if (k_tot == 0)   chk("set_out_col0", {30'b0, set_out}, 32'd0);
        if (k_tot == BPC) chk("set_out_after_col0", {30'b0, set_out}, 32'd1);
        k_tot++;
      end
      if (k_tot < stop_bits) begin
        ph       = ~ph;
        in_valid = cur_toggle ? ph : 1'b1;
        in_data  = cur_words[(wp < 4) ? wp : 3];
        if (in_ready && in_valid) wp++;
        @(negedge wb_clk_i);
        cyc++;
      end
    end
    in_valid = 1'b0;
    if (cyc >= 1000) begin
      checks++;
      errors++;
      $display("FAIL feed_timeout: got no done after %0d cycles expected done", cyc);
    end
  endtask

  task automatic check_final(input logic [1:0] exp_set, input int exp_bits);
    chk("final_done", {31'b0, done}, 32'd1);
    chk("final_fpga_rst", {31'b0, fpga_rst_o}, 32'd0);
    chk("final_set_out", {30'b0, set_out}, {30'b0, exp_set});
    chk("final_busy", {31'b0, busy}, 32'd0);
    chk("final_cen", {30'b0, cen}, 32'd0);
    chk("final_bit_cnt", {26'b0, bit_cnt}, 32'(BPC));
    chk("final_col_idx", {31'b0, col_idx}, 32'd1);
    chk("final_cen_cycles", 32'(k_tot), 32'(exp_bits));
  endtask

  initial begin
    vecs[0] = '{mk(32'hA5A5A5A5, 32'h000000FF, 32'hFFFFFFFF, 32'h00000001), 1'b0, 2'b11, 80};
    vecs[1] = '{mk(32'hA5A5A5A5, 32'h000000FF, 32'hFFFFFFFF, 32'h00000001), 1'b1, 2'b11, 80};
    vecs[2] = '{mk(32'h12345678, 32'hDEADBEEF, 32'h0F0F0F0F, 32'h80000000), 1'b1, 2'b11, 80};

    // Reset state
    @(negedge wb_clk_i);
    chk("rst_fpga_rst", {31'b0, fpga_rst_o}, 32'd1);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_cen", {30'b0, cen}, 32'd0);
    chk("rst_set_out", {30'b0, set_out}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
    chk("rst_bit_cnt", {26'b0, bit_cnt}, 32'd0);
    wb_rst_i = 1'b0;
    @(negedge wb_clk_i);

    // Full passes: held valid, toggled valid, different data
    for (int i = 0; i < 3; i++) begin
      begin_pass(vecs[i].words, vecs[i].toggle);
      chk("pass_busy", {31'b0, busy}, 32'd1);
      feed(1000);
      check_final(vecs[i].exp_set, vecs[i].exp_bits);
    end

    // Abort in DONE has no effect
    abort = 1'b1;
    @(negedge wb_clk_i);
    abort = 1'b0;
    chk("abort_done_done", {31'b0, done}, 32'd1);
    chk("abort_done_set", {30'b0, set_out}, 32'd3);
    chk("abort_done_rst", {31'b0, fpga_rst_o}, 32'd0);

    // Abort after 20 column-0 bits, then a clean pass
    begin_pass(vecs[0].words, 1'b0);
    feed(20);
    abort = 1'b1;
    @(negedge wb_clk_i);
    abort = 1'b0;
    chk("abort_cen", {30'b0, cen}, 32'd0);
    chk("abort_set_out", {30'b0, set_out}, 32'd0);
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_fpga_rst", {31'b0, fpga_rst_o}, 32'd1);
    chk("abort_in_ready", {31'b0, in_ready}, 32'd0);
    chk("abort_done", {31'b0, done}, 32'd0);
    begin_pass(vecs[0].words, 1'b0);
    feed(1000);
    check_final(2'b11, 80);

    // Start during SHIFT is ignored; start in DONE restarts
    begin_pass(vecs[2].words, 1'b0);
    feed(10);
    start = 1'b1;
    @(negedge wb_clk_i);
    start = 1'b0;
    chk("start_shift_bit_cnt", {26'b0, bit_cnt}, 32'd10);
    chk("start_shift_col_idx", {31'b0, col_idx}, 32'd0);
    chk("start_shift_cen", {30'b0, cen}, 32'd1);
    feed(1000);
    check_final(2'b11, 80);
    begin_pass(vecs[0].words, 1'b0);
    chk("restart_set_out", {30'b0, set_out}, 32'd0);
    chk("restart_done", {31'b0, done}, 32'd0);
    chk("restart_fpga_rst", {31'b0, fpga_rst_o}, 32'd1);
    chk("restart_in_ready", {31'b0, in_ready}, 32'd1);
    chk("restart_bit_cnt", {26'b0, bit_cnt}, 32'd0);
    feed(1000);
    check_final(2'b11, 80);

    // Asynchronous reset mid-SHIFT, away from any clock edge
    begin_pass(vecs[1].words, 1'b0);
    feed(15);
    #2 wb_rst_i = 1'b1;
    #1;
    chk("arst_cen", {30'b0, cen}, 32'd0);
    chk("arst_busy", {31'b0, busy}, 32'd0);
    chk("arst_fpga_rst", {31'b0, fpga_rst_o}, 32'd1);
    chk("arst_bit_cnt", {26'b0, bit_cnt}, 32'd0);
    chk("arst_shift_out", {31'b0, shift_out}, 32'd0);
    chk("arst_set_out", {30'b0, set_out}, 32'd0);
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    @(negedge wb_clk_i);

    // Abort and start together while busy: abort wins
    begin_pass(vecs[0].words, 1'b0);
    feed(5);
    abort = 1'b1;
    start = 1'b1;
    @(negedge wb_clk_i);
    abort = 1'b0;
    start = 1'b0;
    chk("abst_busy", {31'b0, busy}, 32'd0);
    chk("abst_cen", {30'b0, cen}, 32'd0);
    chk("abst_in_ready", {31'b0, in_ready}, 32'd0);
    @(negedge wb_clk_i);
    chk("abst_stays_idle", {31'b0, busy}, 32'd0);
    chk("abst_fpga_rst", {31'b0, fpga_rst_o}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
